nt_node_pipe_mon: RTL and testbench

//  Parametrised successor of the fixed single-cone NT-node subcircuits: WIDTH-lane, DEPTH-stage

---
 rtl/nt_node_pipe_mon_pkg.sv | 33 +++
 rtl/nt_node_pipe_mon_if.sv | 30 +++
 rtl/nt_node_pipe_mon_stage.sv | 50 +++++
 rtl/nt_node_pipe_mon.sv | 114 +++++++++++
 tb/tb_nt_node_pipe_mon.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nt_node_pipe_mon_pkg.sv
// ----------------------------------------------------------------------------
// nt_node_pkg
// Shared definitions for the NT-node mixing pipeline and its trigger monitor.
//   MIX_MAX_W         widest word the mix() helper can process
//   RARE_PAT_DEFAULT  default trigger pattern for the 4-lane configuration
//   mix()             one NAND-mix stage transform for a word of w lanes
// ----------------------------------------------------------------------------
package nt_node_pkg;

    localparam int unsigned MIX_MAX_W = 64;
    localparam int unsigned MIX_IDX_W = $clog2(MIX_MAX_W);

    localparam logic [3:0] RARE_PAT_DEFAULT = 4'b1111;

    // Lane i becomes ~(v[i] & ~v[i+1]), with the neighbour index wrapping at w.
    // Lanes at or above w are returned as zero.
    function automatic logic [MIX_MAX_W-1:0] mix(input logic [MIX_MAX_W-1:0] v,
                                                 input int unsigned          w);
        logic [MIX_MAX_W-1:0] r;
        logic [MIX_IDX_W-1:0] idx;
        logic [MIX_IDX_W-1:0] nxt;
        r = '0;
        for (int unsigned i = 0; i < MIX_MAX_W; i++) begin
            idx = MIX_IDX_W'(i);
            nxt = (i + 1 >= w) ? '0 : MIX_IDX_W'(i + 1);
            if (i < w) begin
                r[idx] = ~(v[idx] & ~v[nxt]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nt_node_pipe_mon_if.sv
// ----------------------------------------------------------------------------
// nt_node_pipe_mon_if
// Valid/ready word interface around the NT-node pipeline.
//   in_valid/in_ready/in_data     upstream word handshake
//   out_valid/out_ready/out_data  downstream word handshake
// slave  : the pipeline side (takes input words, produces output words)
// master : the environment side (stimulus source and output sink)
// ----------------------------------------------------------------------------
interface nt_node_pipe_mon_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/nt_node_pipe_mon_stage.sv
// ----------------------------------------------------------------------------
// nt_node_stage
// One registered NAND-mix pipeline stage with valid/ready flow control.
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_valid     valid of the upstream stage (or source)
//   i_data      data of the upstream stage (or source)
//   i_ready_dn  ready seen from the downstream side
//   o_valid     registered stage valid
//   o_data      registered stage data (mix of the loaded word)
//   o_ready_c   combinational: stage can load this cycle
// ----------------------------------------------------------------------------
module nt_node_stage
    import nt_node_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready_dn,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ready_c
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_mix;

    assign w_mix     = WIDTH'(mix(MIX_MAX_W'(i_data), WIDTH));
    // An empty stage can always load; a full one only if its word moves on.
    assign o_ready_c = ~r_valid | i_ready_dn;

    // Stage register: load on ready, otherwise hold data and valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready_c) begin
            r_valid <= i_valid;
            r_data  <= w_mix;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/nt_node_pipe_mon.sv
// ----------------------------------------------------------------------------
// nt_node_pipe_mon
// WIDTH-lane, DEPTH-stage NAND-mix pipeline with valid/ready flow control and
// a saturating rare-pattern hit counter with a sticky alarm.
//   I1470_clk  clock, rising edge
//   I1477_rst  asynchronous active-high reset
//   bus        slave side of the word handshake (in_* / out_*)
//   mon_clr    synchronous clear of rare_cnt and alarm (wins over a hit)
//   rare_cnt   saturating count of delivered words equal to RARE_PAT
//   alarm      sticky flag: rare_cnt has reached THRESH
// ----------------------------------------------------------------------------
module nt_node_pipe_mon
    import nt_node_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      DEPTH    = 3,
    parameter int unsigned      CNT_W    = 8,
    parameter logic [WIDTH-1:0] RARE_PAT = WIDTH'(RARE_PAT_DEFAULT),
    parameter int unsigned      THRESH   = 16
) (
    input  logic              I1470_clk,
    input  logic              I1477_rst,
    nt_node_pipe_mon_if.slave bus,
    input  logic              mon_clr,
    output logic [CNT_W-1:0]  rare_cnt,
    output logic              alarm
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0] w_stage_vld;
    logic [DEPTH-1:0] w_stage_rdy;
    logic [WIDTH-1:0] w_stage_dat [DEPTH];
    logic             w_unused_rdy;

    // Pipeline stages. Downstream ready of stage k is derived straight from the
    // registered valids behind it (a bubble anywhere downstream, or out_ready),
    // which equals the chained ready without a combinational loop through the
    // ready vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_vld_in;
        logic [WIDTH-1:0] w_dat_in;
        logic             w_rdy_dn;

        if (k == 0) begin : g_head
            assign w_vld_in = bus.in_valid;
            assign w_dat_in = bus.in_data;
        end else begin : g_body
            assign w_vld_in = w_stage_vld[k-1];
            assign w_dat_in = w_stage_dat[k-1];
        end

        if (k == DEPTH - 1) begin : g_tail_rdy
            assign w_rdy_dn = bus.out_ready;
        end else begin : g_mid_rdy
            assign w_rdy_dn = bus.out_ready | ~(&w_stage_vld[DEPTH-1:k+1]);
        end

        nt_node_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .i_clk      (I1470_clk),
            .i_rst      (I1477_rst),
            .i_valid    (w_vld_in),
            .i_data     (w_dat_in),
            .i_ready_dn (w_rdy_dn),
            .o_valid    (w_stage_vld[k]),
            .o_data     (w_stage_dat[k]),
            .o_ready_c  (w_stage_rdy[k])
        );
    end

    assign bus.in_ready  = w_stage_rdy[0];
    assign bus.out_valid = w_stage_vld[DEPTH-1];
    assign bus.out_data  = w_stage_dat[DEPTH-1];
    // Inner stage readies are only needed inside their own stage.
    assign w_unused_rdy  = ^w_stage_rdy;

    // Rare-pattern monitor.
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_alarm;

    assign w_hit = bus.out_valid & bus.out_ready & (bus.out_data == RARE_PAT);

    // Saturating increment; never wraps back to zero.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_hit && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Counter and sticky alarm; clear takes priority over a same-cycle hit.
    always_ff @(posedge I1470_clk or posedge I1477_rst) begin
        if (I1477_rst) begin
            r_cnt   <= '0;
            r_alarm <= 1'b0;
        end else if (mon_clr) begin
            r_cnt   <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (32'(w_cnt_nxt) >= THRESH) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign rare_cnt = r_cnt;
    assign alarm    = r_alarm;

endmodule

// File: tb/tb_nt_node_pipe_mon.sv
// ----------------------------------------------------------------------------
// tb_nt_node_pipe_mon
// Self-checking bench for nt_node_pipe_mon (WIDTH=4, DEPTH=3, CNT_W=8,
// THRESH=16, RARE_PAT=4'b1111). A word-level model (in-order queue of
// expected outputs, in-flight occupancy, saturating hit counter) is compared
// against the DUT on every falling edge; directed phases add literal checks.
// ----------------------------------------------------------------------------
module tb_nt_node_pipe_mon;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned THRESH = 16;
    localparam logic [3:0]  RARE   = 4'b1111;

    logic             clk;
    logic             rst;
    logic             mon_clr;
    logic [CNT_W-1:0] rare_cnt;
    logic             alarm;

    nt_node_pipe_mon_if #(.WIDTH(WIDTH)) bus ();

    nt_node_pipe_mon #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W),
        .RARE_PAT (RARE),
        .THRESH   (THRESH)
    ) dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .bus       (bus),
        .mon_clr   (mon_clr),
        .rare_cnt  (rare_cnt),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One lane-wise stage of the mixing rule, then the full three-stage path.
    function automatic logic [3:0] mix_m(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = !((v[i] == 1'b1) && (v[(i + 1) % 4] == 1'b0));
        end
        return r;
    endfunction

    function automatic logic [3:0] path_m(input logic [3:0] v);
        return mix_m(mix_m(mix_m(v)));
    endfunction

    // ---------------- word-level model + per-cycle compare ----------------
    logic [3:0] q[$];
    int         m_cnt   = 0;
    bit         m_alarm = 1'b0;
    bit         prev_stall = 1'b0;
    logic [3:0] prev_data  = '0;
    int         n_deliv = 0;

    always @(negedge clk) begin
        bit hit;
        if (rst) begin
            q.delete();
            m_cnt      = 0;
            m_alarm    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            // in_ready drops only when every stage holds a word and the sink stalls
            check("in_ready", 32'(bus.in_ready),
                  32'(!((q.size() == DEPTH) && !bus.out_ready)));
            check("rare_cnt", 32'(rare_cnt), 32'(m_cnt));
            check("alarm", 32'(alarm), 32'(m_alarm));
            if (prev_stall) begin
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                check("stall_out_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid) begin
                if (q.size() == 0) check("out_valid_no_word", 32'(bus.out_valid), 32'd0);
                else               check("out_data", 32'(bus.out_data), 32'(q[0]));
            end
            hit = 1'b0;
            if (bus.out_valid && bus.out_ready && (q.size() > 0)) begin
                hit = (q[0] == RARE);
                void'(q.pop_front());
                n_deliv++;
            end
            if (bus.in_valid && bus.in_ready) q.push_back(path_m(bus.in_data));
            if (mon_clr) begin
                m_cnt   = 0;
                m_alarm = 1'b0;
            end else if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt >= THRESH) m_alarm = 1'b1;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'b0000;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    logic [3:0] st_words [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [3:0] bp_words [8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h1, 4'h2};

    initial begin
        int base;
        int idx;
        bit ok;

        rst           = 1'b1;
        mon_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2;
        check("init_out_valid", 32'(bus.out_valid), 32'd0);
        check("init_in_ready", 32'(bus.in_ready), 32'd1);
        check("init_rare_cnt", 32'(rare_cnt), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Latency: single word 1010 appears as 0101 after three register stages.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1010;
        #1;
        check("lat_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lat_out_valid_%0d", k), 32'(bus.out_valid), (k == 2) ? 32'd1 : 32'd0);
            if (k == 2) check("lat_out_data", 32'(bus.out_data), 32'h5);
            tick();
        end

        // Stream: 8 back-to-back words, no stall.
        base = n_deliv;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = st_words[i];
            #1;
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (5) tick();
        check("stream_delivered", 32'(n_deliv - base), 32'd8);
        check("stream_queue_empty", 32'(q.size()), 32'd0);

        // Backpressure: sink stalls for the first 5 cycles; source holds words.
        base = n_deliv;
        idx  = 0;
        for (int cyc = 0; (cyc < 60) && (idx < 8); cyc++) begin
            bus.out_ready = (cyc >= 5);
            bus.in_valid  = 1'b1;
            bus.in_data   = bp_words[idx];
            #1;
            if ((cyc == 3) || (cyc == 4))
                check($sformatf("bp_in_ready_full_c%0d", cyc), 32'(bus.in_ready), 32'd0);
            if (cyc == 4) begin
                check("bp_accepted_in_stall", 32'(idx), 32'd3);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_out_data", 32'(bus.out_data), 32'hB);
            end
            if (bus.in_ready) idx++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_all_sent", 32'(idx), 32'd8);
        repeat (6) tick();
        check("bp_delivered", 32'(n_deliv - base), 32'd8);
        check("bp_queue_empty", 32'(q.size()), 32'd0);

        // Monitor: threshold crossing on the 16th hit, then saturation.
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        send_zeros(15);
        repeat (4) tick();
        check("mon_cnt_15", 32'(rare_cnt), 32'd15);
        check("mon_alarm_15", 32'(alarm), 32'd0);
        send_zeros(1);
        repeat (4) tick();
        check("mon_cnt_16", 32'(rare_cnt), 32'd16);
        check("mon_alarm_16", 32'(alarm), 32'd1);
        send_zeros(300);
        repeat (4) tick();
        check("mon_cnt_sat", 32'(rare_cnt), 32'd255);
        check("mon_alarm_sat", 32'(alarm), 32'd1);

        // Reset mid-stream: pipeline full and stalled, then async reset.
        bus.out_ready = 1'b0;
        send_zeros(3);
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rare_cnt", 32'(rare_cnt), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        repeat (2) tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Clear race: clear in the same cycle as a hit drops that hit.
        send_zeros(1);
        repeat (4) tick();
        check("clr_pre_cnt", 32'(rare_cnt), 32'd1);
        send_zeros(1);
        wait_ov(ok);
        check("clr_wait_out_valid", 32'(ok), 32'd1);
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        check("clr_race_cnt", 32'(rare_cnt), 32'd0);
        check("clr_race_alarm", 32'(alarm), 32'd0);
        send_zeros(1);
        repeat (4) tick();
        check("clr_next_hit_cnt", 32'(rare_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
